// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for a bank of common-select 7-segment digits.
// Each digit gets one fixed-length slot. A slot starts with a short blanking window
// (no digit selected) and then drives that digit's pattern. New display data is held
// in a pending buffer and only moves to the active buffer between frames, so a frame
// never shows a mix of old and new data. Each digit can also be disabled or set to blink.

module seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 5_000,
    parameter int BLANK_CYCLES = 250,
    parameter int BLINK_FRAMES = 625,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit SEL_ACT_LOW  = 1'b1
) (
    input  logic                      clk50MHz,
    input  logic                      rst,
    input  logic [8*NUM_DIGITS-1:0]   seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_en,
    input  logic [NUM_DIGITS-1:0]     blink_en,
    input  logic                      load,
    output logic [7:0]                ledout,
    output logic [NUM_DIGITS-1:0]     ledsel,
    output logic                      frame_done
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int IW  = $clog2(NUM_DIGITS);
    localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] LAST_COUNT = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? PW'(BLANK_CYCLES - 1) : '0;
    localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // XOR masks that turn "1 = lit / selected" into the board's pin polarity.
    localparam logic [7:0]            SEG_MASK = {8{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] SEL_MASK = {NUM_DIGITS{SEL_ACT_LOW}};

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [PW-1:0]             prescale;
    logic [IW-1:0]             digit_idx;
    logic                      slot_end;
    logic                      blank_end;
    logic                      frame_end;

    logic [8*NUM_DIGITS-1:0]   active_seg;
    logic [NUM_DIGITS-1:0]     active_en;
    logic [NUM_DIGITS-1:0]     active_blink;
    logic [8*NUM_DIGITS-1:0]   pend_seg;
    logic [NUM_DIGITS-1:0]     pend_en;
    logic [NUM_DIGITS-1:0]     pend_blink;
    logic                      pend_flag;

    logic [BW-1:0]             blink_cnt;
    logic                      blink_phase;

    logic [NUM_DIGITS-1:0]     sel_raw;
    logic [7:0]                seg_raw;

    assign slot_end  = (prescale == LAST_COUNT);
    assign blank_end = (prescale == BLANK_LAST);
    assign frame_end = slot_end && (digit_idx == LAST_DIGIT);

    // Slot prescaler: free-running 0..DIV-1, one wrap per digit slot.
    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            prescale <= '0;
        end else if (slot_end) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // Digit index advances at every slot end and wraps after the last digit.
    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            digit_idx <= '0;
        end else if (slot_end) begin
            digit_idx <= (digit_idx == LAST_DIGIT) ? '0 : digit_idx + 1'b1;
        end
    end

    // Scan state register.
    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            state <= ST_BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the un-inverted select/segment values for the current slot.
    // With no blanking window the slot goes straight back to DRIVE.
    always_comb begin
        state_nxt = state;
        sel_raw   = '0;
        seg_raw   = '0;
        if (slot_end) begin
            state_nxt = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
        end else if (state == ST_BLANK && (BLANK_CYCLES == 0 || blank_end)) begin
            state_nxt = ST_DRIVE;
        end
        if (state == ST_DRIVE) begin
            sel_raw = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx;
            if (active_en[digit_idx] && !(active_blink[digit_idx] && blink_phase)) begin
                seg_raw = active_seg[8*digit_idx +: 8];
            end
        end
    end

    // Blink timing: the phase flips every BLINK_FRAMES frames.
    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Double buffer: loads land in pending and are promoted only at a frame
    // boundary; a load on the boundary cycle itself goes straight to active.
    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            active_seg   <= '0;
            active_en    <= '0;
            active_blink <= '0;
            pend_seg     <= '0;
            pend_en      <= '0;
            pend_blink   <= '0;
            pend_flag    <= 1'b0;
        end else if (frame_end) begin
            pend_flag <= 1'b0;
            if (load) begin
                active_seg   <= seg_in;
                active_en    <= dig_en;
                active_blink <= blink_en;
            end else if (pend_flag) begin
                active_seg   <= pend_seg;
                active_en    <= pend_en;
                active_blink <= pend_blink;
            end
        end else if (load) begin
            pend_seg   <= seg_in;
            pend_en    <= dig_en;
            pend_blink <= blink_en;
            pend_flag  <= 1'b1;
        end
    end

    // Output register: polarity applied here only; reset forces everything inactive.
    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            ledout     <= SEG_MASK;
            ledsel     <= SEL_MASK;
            frame_done <= 1'b0;
        end else begin
            ledout     <= seg_raw ^ SEG_MASK;
            ledsel     <= sel_raw ^ SEL_MASK;
            frame_done <= frame_end;
        end
    end

endmodule
